// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin sharing of one external combinational ALU among NUM_REQ requesters.
// Optional ALU_STICKY_OVER_EN adds per-requester sticky overflow flags.
module alu_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 8,
  parameter int ID_W = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]      req_op,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [2:0]                alu_op,
  input  logic [DATA_W-1:0]         alu_out,
  input  logic                      alu_carry,
  input  logic                      alu_sign,
  input  logic                      alu_over,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [2:0]                rsp_flags,
  output logic                      busy,
  input  logic                      sticky_clr,
  output logic [NUM_REQ-1:0]        sticky_over
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nxt;
  logic [ID_W-1:0] rr_ptr, grant, cand;
  logic any_valid;
  // Scan from the farthest offset down so the nearest valid index after rr_ptr wins.
  always_comb begin
    grant = '0;
    any_valid = 1'b0;
    cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        grant = cand;
        any_valid = 1'b1;
      end
    end
  end
  assign req_ready = (state == IDLE && any_valid) ? NUM_REQ'(1) << grant : '0;
  assign rsp_valid = state == RESP;
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (any_valid ? EXEC : IDLE) :
                state == EXEC ? RESP :
                (rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a <= '0;
      alu_b <= '0;
      alu_op <= '0;
      rsp_id <= '0;
      rsp_data <= '0;
      rsp_flags <= '0;
      rr_ptr <= '0;
    end else begin
      if (state == IDLE && any_valid) begin
        alu_a <= req_a[grant*DATA_W +: DATA_W];
        alu_b <= req_b[grant*DATA_W +: DATA_W];
        alu_op <= req_op[grant*3 +: 3];
        rsp_id <= grant;
      end
      if (state == EXEC) begin
        rsp_data <= alu_out;
        rsp_flags <= {alu_carry, alu_sign, alu_over};
        rr_ptr <= rsp_id == ID_W'(NUM_REQ - 1) ? '0 : rsp_id + 1'b1;
      end
    end
  end
`ifdef ALU_STICKY_OVER_EN
  // A set in the same cycle as a clear survives for that bit.
  always_ff @(posedge clk or posedge rst)
    if (rst) sticky_over <= '0;
    else sticky_over <= (sticky_clr ? '0 : sticky_over) |
                        ((state == EXEC && alu_over) ? NUM_REQ'(1) << rsp_id : '0);
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = sticky_clr;
  assign sticky_over = '0;
`endif
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter: self-checking bench with a local ALU and a transaction-level arbiter model.
module tb_alu_rr_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] req_valid, req_ready, sticky_over;
  logic [31:0] req_a, req_b;
  logic [11:0] req_op;
  logic [7:0] alu_a, alu_b, alu_out, rsp_data;
  logic [2:0] alu_op, rsp_flags;
  logic alu_carry, alu_sign, alu_over, rsp_valid, rsp_ready, busy, sticky_clr;
  logic [1:0] rsp_id;
  int checks = 0, fails = 0;
  int ptr = 0;
  logic [3:0] vmask = '0, sticky_m = '0;
  logic [7:0] ma[4], mb[4];
  logic [2:0] mo[4];
  logic [7:0] last_data;
  logic [2:0] last_flags;
  int rsp_log[$];
  logic [10:0] pend;

  always #5 clk = ~clk;

  alu_rr_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .alu_carry(alu_carry), .alu_sign(alu_sign), .alu_over(alu_over),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .busy(busy),
    .sticky_clr(sticky_clr), .sticky_over(sticky_over)
  );

  // ALU behaviour: returns {carry, sign, over, out}
  function automatic logic [10:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    logic [8:0] r;
    logic o;
    o = 1'b0;
    case (op)
      3'd0: begin r = {1'b0, a} + {1'b0, b}; o = (a[7] == b[7]) && (r[7] != a[7]); end
      3'd1: begin r = {1'b0, a} - {1'b0, b}; o = (a[7] != b[7]) && (r[7] != a[7]); end
      3'd2: r = {1'b0, a & b};
      3'd3: r = {1'b0, a | b};
      3'd4: r = {1'b0, a ^ b};
      3'd5: r = {1'b0, ~a};
      3'd6: r = {a, 1'b0};
      default: r = {a[0], 1'b0, a[7:1]};
    endcase
    return {r[8], r[7], o, r[7:0]};
  endfunction

  assign {alu_carry, alu_sign, alu_over, alu_out} = alu_f(alu_a, alu_b, alu_op);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_a[i*8 +: 8] = ma[i];
      req_b[i*8 +: 8] = mb[i];
      req_op[i*3 +: 3] = mo[i];
    end
    req_valid = vmask;
  endtask

  function automatic int exp_grant();
    for (int k = 0; k < 4; k++)
      if (vmask[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  // Run until n responses arrive; entered and left just after a falling edge with the DUT idle.
  task automatic serve(input int n, input bit oneshot, input bit chk_rate);
    int got = 0, cyc = 0, acc_cyc = -10, prev_acc = -1, acc_id = 0, eg, pend_id = 0;
    bit just_acc = 0;
    logic [10:0] p = '0;
    while (got < n && cyc < 200) begin
      #1;
      if (req_ready != 0) begin
        eg = exp_grant();
        chk("grant", req_ready, eg < 0 ? 0 : 32'd1 << eg);
        if (eg < 0) eg = 0;
        if (chk_rate && prev_acc >= 0) chk("rate", cyc - prev_acc, 3);
        prev_acc = cyc;
        acc_cyc = cyc;
        acc_id = eg;
        pend_id = eg;
        p = alu_f(ma[eg], mb[eg], mo[eg]);
        just_acc = 1;
      end
      if (rsp_valid) begin
        chk("latency", cyc - acc_cyc, 2);
        chk("rsp_id", rsp_id, pend_id);
        chk("rsp_data", rsp_data, p[7:0]);
        chk("rsp_flags", rsp_flags, p[10:8]);
`ifdef ALU_STICKY_OVER_EN
        if (p[8]) sticky_m[pend_id] = 1'b1;
`endif
        chk("sticky", sticky_over, sticky_m);
        last_data = rsp_data;
        last_flags = rsp_flags;
        rsp_log.push_back(int'(rsp_id));
        ptr = (pend_id + 1) % 4;
        got++;
      end
      @(negedge clk);
      cyc++;
      if (just_acc) begin
        just_acc = 0;
        if (oneshot) vmask[acc_id] = 1'b0;
        else begin
          ma[acc_id] = 8'($urandom);
          mb[acc_id] = 8'($urandom);
        end
        drive();
      end
    end
    chk("serve_done", got, n);
    vmask = '0;
    drive();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      ma[i] = '0;
      mb[i] = '0;
      mo[i] = '0;
    end
    rsp_ready = 1'b1;
    sticky_clr = 1'b0;
    drive();
    @(negedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu", {alu_a, alu_b, alu_op}, 0);
    chk("rst_rsp", {rsp_id, rsp_data, rsp_flags}, 0);
    chk("rst_sticky", sticky_over, 0);
    rst = 1'b0;
    // all four continuously valid, AND op, random operands
    for (int i = 0; i < 4; i++) begin
      ma[i] = 8'($urandom);
      mb[i] = 8'($urandom);
      mo[i] = 3'b010;
    end
    vmask = 4'b1111;
    drive();
    serve(5, 0, 1);
    chk("t2_order0", rsp_log[0], 0);
    chk("t2_order4", rsp_log[4], 0);
    // single add on requester 0
    ma[0] = 8'h28; mb[0] = 8'h23; mo[0] = 3'b000;
    vmask = 4'b0001;
    drive();
    serve(1, 1, 0);
    chk("t1_data", last_data, 8'h4B);
    chk("t1_flags", last_flags, 3'b000);
    // signed overflow on requester 2
    ma[2] = 8'h4A; mb[2] = 8'h57; mo[2] = 3'b000;
    vmask = 4'b0100;
    drive();
    serve(1, 1, 0);
    chk("t3_data", last_data, 8'hA1);
    chk("t3_flags", last_flags, 3'b011);
    #1;
`ifdef ALU_STICKY_OVER_EN
    chk("t3_sticky_set", sticky_over, 4'b0100);
`else
    chk("t3_sticky_set", sticky_over, 4'b0000);
`endif
    sticky_clr = 1'b1;
    @(negedge clk);
    sticky_clr = 1'b0;
    #1;
    chk("t3_sticky_clr", sticky_over, 0);
    sticky_m = '0;
    // response back-pressure
    ma[1] = 8'h5C; mb[1] = 8'h3A; mo[1] = 3'b010;
    vmask = 4'b0010;
    rsp_ready = 1'b0;
    drive();
    #1;
    chk("t4_accept", req_ready, exp_grant() < 0 ? 0 : 32'd1 << exp_grant());
    pend = alu_f(ma[1], mb[1], mo[1]);
    @(negedge clk);
    vmask = 4'b1101;
    drive();
    #1;
    chk("t4_exec_busy", busy, 1);
    chk("t4_exec_ready", req_ready, 0);
    @(negedge clk);
    #1;
    chk("t4_rsp_valid", rsp_valid, 1);
    ptr = 2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("t4_stall_valid", rsp_valid, 1);
      chk("t4_stall_id", rsp_id, 1);
      chk("t4_stall_data", rsp_data, pend[7:0]);
      chk("t4_stall_flags", rsp_flags, pend[10:8]);
      chk("t4_stall_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("t4_resume", req_ready, 32'd1 << exp_grant());
    vmask = '0;
    drive();
    // reset while requester 1 is executing
    ma[1] = 8'($urandom); mb[1] = 8'($urandom); mo[1] = 3'b001;
    vmask = 4'b0010;
    drive();
    #1;
    chk("t5_accept", req_ready, 4'b0010);
    @(negedge clk);
    vmask = '0;
    drive();
    #1;
    chk("t5_exec_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", rsp_valid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_ready", req_ready, 0);
    chk("t5_rst_alu", {alu_a, alu_b, alu_op}, 0);
    chk("t5_rst_rsp", {rsp_id, rsp_data, rsp_flags}, 0);
    chk("t5_rst_sticky", sticky_over, 0);
    @(negedge clk);
    #1;
    chk("t5_no_rsp", rsp_valid, 0);
    ptr = 0;
    sticky_m = '0;
    rsp_log.delete();
    for (int i = 0; i < 2; i++) begin
      ma[i] = 8'($urandom);
      mb[i] = 8'($urandom);
      mo[i] = 3'($urandom);
    end
    rst = 1'b0;
    vmask = 4'b0011;
    drive();
    serve(1, 1, 0);
    chk("t5_first", rsp_log[0], 0);
    // requesters 3 and 1 together, ordered by the pointer
    rsp_log.delete();
    ma[3] = 8'h81; mb[3] = 8'($urandom); mo[3] = 3'b111;
    ma[1] = 8'h70; mb[1] = 8'($urandom); mo[1] = 3'b101;
    vmask = 4'b1010;
    drive();
    serve(2, 1, 0);
    chk("t6_first", rsp_log[0], 1);
    chk("t6_second", rsp_log[1], 3);
    chk("t6_data", last_data, alu_f(8'h81, mb[3], 3'b111) & 11'h0FF);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
